// File: rtl/rom_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_boot_ctrl_if
// Brief    : Image stream, ROM write/monitor and CPU run-control bundle.
// Revision : 1.0
// ============================================================================
interface rom_boot_ctrl_if;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_ready;
   logic        rom_we;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_wdata;
   logic        cpu_reset_n;
   logic [7:0]  pc;
   logic [7:0]  ir;
   logic [7:0]  mon_addr;
   logic [7:0]  mon_data;
   logic        busy;
   logic        halted;
   logic        timeout;
   logic        oversize;
   logic [15:0] run_cycles;

   modport slave (
      input  start, s_valid, s_data, s_last, pc, ir, mon_data,
      output s_ready, rom_we, rom_addr, rom_wdata, cpu_reset_n, mon_addr,
             busy, halted, timeout, oversize, run_cycles
   );

   modport master (
      output start, s_valid, s_data, s_last, pc, ir, mon_data,
      input  s_ready, rom_we, rom_addr, rom_wdata, cpu_reset_n, mon_addr,
             busy, halted, timeout, oversize, run_cycles
   );
endinterface
`default_nettype wire

// File: rtl/rom_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_boot_ctrl
// Brief    : Loads a byte-stream image into program ROM, holds/releases the
//            CPU reset, then watches for the BRA * halt idiom or a watchdog.
// Revision : 1.0
// ============================================================================
module rom_boot_ctrl #(
   parameter int unsigned WATCHDOG  = 2000,
   parameter int unsigned RESET_CYC = 2,
   parameter logic [7:0]  HALT_OP   = 8'h20,
   parameter logic [7:0]  HALT_OFF  = 8'hFE
) (
   input  logic           clk,
   input  logic           reset,
   rom_boot_ctrl_if.slave sif
);
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_HALT  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam logic [15:0] c_WD_LIMIT  = 16'(WATCHDOG);
   localparam logic [15:0] c_HOLD_LAST = 16'(RESET_CYC);

   state_t      r_state, w_state;
   logic [7:0]  r_idx, w_idx;
   logic [15:0] r_hold, w_hold;
   logic        r_rom_we, w_rom_we;
   logic [7:0]  r_rom_addr, w_rom_addr;
   logic [7:0]  r_rom_wdata, w_rom_wdata;
   logic        r_cpu_rst_n, w_cpu_rst_n;
   logic        r_halted, w_halted;
   logic        r_timeout, w_timeout;
   logic        r_oversize, w_oversize;
   logic [15:0] r_run, w_run;
   logic [15:0] w_run_inc;
   logic        w_accept;
   logic        w_halt_hit;
   logic        w_wd_hit;

   assign w_accept  = (r_state == ST_LOAD) && sif.s_valid;
   assign w_run_inc = (r_run == 16'hFFFF) ? r_run : (r_run + 16'd1);
   // r_run is still zero during the first RUN cycle, which masks the halt check
   assign w_halt_hit = (r_run != 16'd0) && (sif.ir == HALT_OP) && (sif.mon_data == HALT_OFF);
   assign w_wd_hit   = (w_run_inc == c_WD_LIMIT);

   always_comb begin
      w_state     = r_state;
      w_idx       = r_idx;
      w_hold      = r_hold;
      w_rom_we    = 1'b0;
      w_rom_addr  = r_rom_addr;
      w_rom_wdata = r_rom_wdata;
      w_cpu_rst_n = r_cpu_rst_n;
      w_halted    = r_halted;
      w_timeout   = r_timeout;
      w_oversize  = r_oversize;
      w_run       = r_run;
      case (r_state)
         ST_IDLE, ST_HALT, ST_FAULT: begin
            if (sif.start) begin
               w_state     = ST_LOAD;
               w_idx       = 8'd0;
               w_hold      = 16'd0;
               w_cpu_rst_n = 1'b0;
               w_halted    = 1'b0;
               w_timeout   = 1'b0;
               w_oversize  = 1'b0;
               w_run       = 16'd0;
            end
         end
         ST_LOAD: begin
            if (w_accept) begin
               w_rom_we    = 1'b1;
               w_rom_addr  = r_idx;
               w_rom_wdata = sif.s_data;
               if (r_idx != 8'hFF) begin
                  w_idx = r_idx + 8'd1;
               end
               if (sif.s_last) begin
                  w_state = ST_HOLD;
                  w_hold  = 16'd0;
               end else if (r_idx == 8'hFF) begin
                  w_state    = ST_FAULT;
                  w_oversize = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            // One extra count covers the final ROM write cycle before release
            if (r_hold == c_HOLD_LAST) begin
               w_state     = ST_RUN;
               w_cpu_rst_n = 1'b1;
            end else begin
               w_hold = r_hold + 16'd1;
            end
         end
         ST_RUN: begin
            w_run = w_run_inc;
            if (w_halt_hit) begin
               w_state  = ST_HALT;
               w_halted = 1'b1;
            end else if (w_wd_hit) begin
               w_state     = ST_FAULT;
               w_timeout   = 1'b1;
               w_cpu_rst_n = 1'b0;
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= 8'd0;
         r_hold      <= 16'd0;
         r_rom_we    <= 1'b0;
         r_rom_addr  <= 8'd0;
         r_rom_wdata <= 8'd0;
         r_cpu_rst_n <= 1'b0;
         r_halted    <= 1'b0;
         r_timeout   <= 1'b0;
         r_oversize  <= 1'b0;
         r_run       <= 16'd0;
      end else begin
         r_state     <= w_state;
         r_idx       <= w_idx;
         r_hold      <= w_hold;
         r_rom_we    <= w_rom_we;
         r_rom_addr  <= w_rom_addr;
         r_rom_wdata <= w_rom_wdata;
         r_cpu_rst_n <= w_cpu_rst_n;
         r_halted    <= w_halted;
         r_timeout   <= w_timeout;
         r_oversize  <= w_oversize;
         r_run       <= w_run;
      end
   end

   assign sif.s_ready     = (r_state == ST_LOAD);
   assign sif.busy        = (r_state == ST_LOAD) || (r_state == ST_HOLD) || (r_state == ST_RUN);
   assign sif.rom_we      = r_rom_we;
   assign sif.rom_addr    = r_rom_addr;
   assign sif.rom_wdata   = r_rom_wdata;
   assign sif.cpu_reset_n = r_cpu_rst_n;
   assign sif.halted      = r_halted;
   assign sif.timeout     = r_timeout;
   assign sif.oversize    = r_oversize;
   assign sif.run_cycles  = r_run;
   assign sif.mon_addr    = sif.pc + 8'd1;
endmodule
`default_nettype wire

// File: tb/tb_rom_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_boot_ctrl
// Brief    : Randomized self-checking bench for rom_boot_ctrl.
// Revision : 1.0
// ============================================================================
module tb_rom_boot_ctrl;
   localparam int WD   = 50;
   localparam int RCYC = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   rom_boot_ctrl_if bus();

   logic [7:0]  img [$];
   logic [7:0]  rom_img [256];
   logic [47:0] exp_wr [$];
   logic [47:0] got_wr [$];

   rom_boot_ctrl #(
      .WATCHDOG (WD),
      .RESET_CYC(RCYC),
      .HALT_OP  (8'h20),
      .HALT_OFF (8'hFE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .sif  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM read port as the CPU would see it: the image the bench intends to load
   assign bus.mon_data = rom_img[bus.mon_addr];

   always @(negedge clk) begin
      if (bus.rom_we) got_wr.push_back({32'(cyc), bus.rom_addr, bus.rom_wdata});
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got time %0t required finish", $time);
      $fatal(1, "bench time limit");
   end

   task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic set_image();
      for (int i = 0; i < 256; i++) rom_img[i] = 8'h00;
      for (int i = 0; i < img.size() && i < 256; i++) rom_img[i] = img[i];
   endtask

   task automatic rand_image(input int len);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      img[len-1] = 8'hFE;
      set_image();
   endtask

   // h: RUN cycle in which the halt idiom is presented (0 = never)
   task automatic do_case(input int len, input bit give_last, input int vmode,
                          input int h, input logic [7:0] halt_pc, input bit poke_start);
      int k, t, guard, rise, last_wr, endk, exp_end;
      bit vld, hit;
      exp_wr.delete();
      got_wr.delete();
      bus.ir = 8'h00;
      bus.pc = 8'h00;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      k = 0; t = 0; last_wr = -1;
      while (k < len && t < 2000) begin
         if (!bus.s_ready) break;
         vld = (vmode == 0) ? 1'b1 : (vmode == 1) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
         bus.s_valid = vld;
         bus.s_data  = vld ? img[k] : 8'($urandom);
         bus.s_last  = vld ? (give_last && (k == len - 1)) : 1'($urandom_range(0, 1));
         if (vld) begin
            exp_wr.push_back({32'(cyc + 1), 8'(k), img[k]});
            last_wr = cyc + 1;
            k++;
         end
         t++;
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      chk_value("ready_after_load", bus.s_ready, 1'b0);
      if (!give_last) begin
         repeat (2) @(negedge clk);
         chk_value("oversize_flag", bus.oversize, 1'b1);
         chk_value("oversize_rstn", bus.cpu_reset_n, 1'b0);
         chk_value("oversize_busy", bus.busy, 1'b0);
      end else begin
         guard = 0;
         while (!bus.cpu_reset_n && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         rise = bus.cpu_reset_n ? cyc : -1;
         chk_value("hold_release_cycle", rise, last_wr + 1 + RCYC);
         if (rise >= 0) begin
            hit     = (h >= 2) && (h <= WD);
            exp_end = hit ? h : WD;
            endk    = 0;
            for (int kk = 1; kk <= WD + 5; kk++) begin
               if (kk == 1 || kk == h) begin
                  bus.ir = 8'h20;
                  bus.pc = halt_pc;
               end else begin
                  bus.ir = 8'h21 + 8'($urandom_range(0, 199));
                  bus.pc = (kk == 2) ? 8'hFF : 8'($urandom);
               end
               bus.start = poke_start && (kk == 3);
               #1;
               chk_value("mon_addr", bus.mon_addr, (int'(bus.pc) + 1) % 256);
               @(negedge clk);
               bus.start = 1'b0;
               if (bus.halted || bus.timeout) begin
                  endk = kk;
                  break;
               end
            end
            chk_value("run_end_cycle", endk, exp_end);
            chk_value("halted", bus.halted, hit);
            chk_value("timeout", bus.timeout, !hit);
            chk_value("run_cycles", bus.run_cycles, exp_end);
            chk_value("rstn_at_end", bus.cpu_reset_n, hit);
            chk_value("busy_at_end", bus.busy, 1'b0);
            repeat (3) @(negedge clk);
            chk_value("run_cycles_hold", bus.run_cycles, exp_end);
         end
      end
      chk_value("write_count", got_wr.size(), exp_wr.size());
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
         chk_value("write_cyc_addr_data", got_wr[i], exp_wr[i]);
      end
      bus.ir = 8'h00;
      bus.pc = 8'h00;
   endtask

   initial begin
      int len, h;
      bus.start   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.s_last  = 1'b0;
      bus.pc      = 8'h00;
      bus.ir      = 8'h00;
      img.delete();
      set_image();
      repeat (3) @(negedge clk);
      chk_value("reset_outputs",
                {bus.s_ready, bus.rom_we, bus.cpu_reset_n, bus.halted, bus.timeout,
                 bus.oversize, bus.busy, bus.rom_addr, bus.rom_wdata, bus.run_cycles}, 0);
      bus.pc = 8'hFF;
      #1;
      chk_value("mon_addr_wrap_idle", bus.mon_addr, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // Reference image ending in BRA * at address 4
      img = {8'h10, 8'h05, 8'h30, 8'h00, 8'h20, 8'hFE};
      set_image();
      do_case(6, 1'b1, 0, $urandom_range(2, 20), 8'd4, 1'b0);

      rand_image(4);
      do_case(4, 1'b1, 1, $urandom_range(2, 20), 8'd2, 1'b0);

      rand_image(257);
      do_case(257, 1'b0, 0, 0, 8'd0, 1'b0);

      rand_image(8);
      do_case(8, 1'b1, 0, 0, 8'd6, 1'b0);

      // Halt and watchdog expiry in the same cycle
      rand_image(5);
      do_case(5, 1'b1, 2, WD, 8'd3, 1'b0);

      img = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      set_image();
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = img[i];
         bus.s_last  = 1'b0;
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      chk_value("inflight_write_before_reset", {bus.rom_we, bus.rom_addr, bus.rom_wdata}, {1'b1, 8'd2, 8'h33});
      #2 reset = 1'b1;
      #1;
      chk_value("async_reset_outputs",
                {bus.s_ready, bus.rom_we, bus.cpu_reset_n, bus.halted, bus.timeout,
                 bus.oversize, bus.busy, bus.rom_addr, bus.rom_wdata, bus.run_cycles}, 0);
      @(negedge clk);
      reset = 1'b0;
      img = {8'h20, 8'hFE};
      set_image();
      do_case(2, 1'b1, 0, 20, 8'd0, 1'b1);

      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(2, 24);
         h   = $urandom_range(2, 60);
         rand_image(len);
         do_case(len, 1'b1, $urandom_range(0, 2), h, 8'(len - 2), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rom_boot_ctrl.md
# rom_boot_ctrl

Boot sequencer for the 8-bit computer. It accepts a program image as a byte stream and writes it into the program ROM write port. It holds the CPU in reset during the load, releases it, then supervises execution. Execution ends when the CPU reaches the halt idiom (BRA * : opcode 0x20 followed by 0xFE) or when a watchdog expires. It sits beside `computer`, driving its reset input and the ROM write/monitor ports, so image loading and run control are done in hardware rather than by bench tasks.

## Interface

- `WATCHDOG`, 2000: maximum RUN cycles before timeout (1..65535)
- `RESET_CYC`, 2: cycles CPU reset is held low after the last ROM write (≥1)
- `HALT_OP`, 8'h20: halt-idiom opcode
- `HALT_OFF`, 8'hFE: halt-idiom operand

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: one-cycle request to begin a load
- `s_valid` in 1: image byte valid
- `s_data` in 8: image byte
- `s_last` in 1: marks final image byte
- `s_ready` out 1: byte accepted when `s_valid & s_ready`
- `rom_we` out 1: ROM write strobe
- `rom_addr` out 8: ROM write address
- `rom_wdata` out 8: ROM write data
- `cpu_reset_n` out 1: to `computer.reset`; 0 holds CPU in reset
- `pc` in 8: CPU program counter
- `ir` in 8: CPU instruction register
- `mon_addr` out 8: ROM monitor read address, equal to `pc+1` (mod 256)
- `mon_data` in 8: ROM byte at `mon_addr`, combinational
- `busy` out 1: state is LOAD, HOLD or RUN
- `halted` out 1: halt idiom detected
- `timeout` out 1: watchdog expired
- `oversize` out 1: image exceeded 256 bytes
- `run_cycles` out 16: RUN cycles of the last run, saturating

## Operation

- States: IDLE, LOAD, HOLD, RUN, HALT, FAULT.
- Reset values:
  - state is IDLE.
  - `s_ready`, `rom_we`, `cpu_reset_n`, `halted`, `timeout` and `oversize` are 0.
  - `rom_addr`, `rom_wdata` and `run_cycles` are 0.
  - Internal byte index and hold/watchdog counters are 0.
- IDLE, HALT, FAULT:
  - `start` moves to LOAD.
  - On that transition: clear `halted`, `timeout`, `oversize` and `run_cycles`; set index to 0; set `cpu_reset_n` to 0.
- `start` in LOAD, HOLD or RUN is ignored.
- LOAD:
  - `s_ready`=1 and `cpu_reset_n`=0.
  - Each accepted byte is registered: next cycle `rom_we`=1, `rom_addr`=index, `rom_wdata`=byte. Then index increments.
  - Accepted byte with `s_last`=1 moves to HOLD.
  - Byte accepted at index 255 with `s_last`=0: the byte is still written, then go to FAULT with `oversize`=1.
  - Index never wraps to 0.
- HOLD:
  - `s_ready`=0 and `cpu_reset_n`=0 for exactly `RESET_CYC` cycles, then go to RUN.
- RUN:
  - `cpu_reset_n`=1.
  - `run_cycles` increments every RUN cycle, saturating at 0xFFFF.
  - Halt check is suppressed in the first RUN cycle (CPU leaving reset) and evaluated every cycle after.
  - Halt condition is `ir==HALT_OP && mon_data==HALT_OFF`. On a match go to HALT with `halted`=1; `cpu_reset_n` stays 1 (CPU spins on BRA *).
  - If the RUN cycle count reaches `WATCHDOG` without a halt, go to FAULT with `timeout`=1 and `cpu_reset_n`=0.
  - If halt and watchdog expiry occur in the same cycle, halt wins: HALT, `timeout`=0.
- `mon_addr` is always `pc+1` truncated to 8 bits (pc=0xFF gives 0x00), independent of state.
- Asynchronous `reset` in any state, including mid-LOAD:
  - Immediate return to reset values.
  - ROM bytes already written are not rolled back.
  - Any in-flight `rom_we` is dropped.

## Timing

- Byte accepted at edge N: `rom_we` is high for the cycle after edge N, with its address/data. Back-to-back bytes give continuous `rom_we`.
- `s_ready` falls in the cycle after the last byte is accepted. It is never high outside LOAD.
- Last byte accepted at edge N:
  - HOLD begins at N+1.
  - `cpu_reset_n` rises at edge N+1+`RESET_CYC`.
  - The last write completes before `cpu_reset_n` rises.
- Halt detected at edge M: `halted`=1 and `busy`=0 from M. `run_cycles` holds its final value.
- Watchdog: `timeout` asserts at the edge ending RUN cycle `WATCHDOG`, and `cpu_reset_n` falls at that same edge.

## Test plan

- **Normal load.** `start`, then 6-byte image {0x10,0x05,0x30,0x00,0x20,0xFE} streamed with `s_valid` held 1.
  - Required: writes to addr 0..5 with those bytes, one per cycle.
  - Required: `cpu_reset_n` rises 2 cycles after the final write cycle.
  - Required: when `ir`=0x20 and `pc`=4, `halted`=1 and `run_cycles` equals the cycles counted.
- **Backpressure.** `s_valid` toggled 1,0,0,1,... on a 4-byte image.
  - Required: exactly 4 `rom_we` pulses at addr 0..3.
  - Required: no write in idle gaps.
- **Oversize.** 257 bytes with no `s_last`.
  - Required: 256 writes (addr 0..255), then FAULT with `oversize`=1 and `cpu_reset_n`=0.
  - Required: no write of byte 257.
- **Watchdog.** `WATCHDOG`=50, image never halts (`ir`≠0x20).
  - Required: `timeout`=1 after exactly 50 RUN cycles.
  - Required: `run_cycles`=50 and `cpu_reset_n`=0.
- **Wrap and first-cycle suppression.**
  - `pc`=0xFF: required `mon_addr`=0x00.
  - `ir`=0x20 and `mon_data`=0xFE in the first RUN cycle only: required no halt.
- **Async reset and restart.**
  - Assert `reset` mid-LOAD after 3 bytes. Required: all outputs return to reset values without a clock edge.
  - A new `start` with a 2-byte image then loads from addr 0.
  - `start` pulsed during RUN: required to be ignored.
